// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the PWM sequencer.
// The UP/DOWN states exist only when PWM_SEQ_RAMP_EN is defined.
package pwm_seq_pkg;

  localparam int CNT_W_DEF  = 10;
  localparam int PERIOD_DEF = 999;

`ifdef PWM_SEQ_RAMP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } seq_state_e;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0
  } seq_state_e;
`endif

endpackage

// File: rtl/pwm_seq_if.sv
// Control/status bundle between a PWM sequencer and its host.
interface pwm_seq_if
  import pwm_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             en;
  logic             duty_we;
  logic [CNT_W-1:0] duty_in;
  logic             pwm;
  logic             period_tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] duty_act;

  modport master (
    output en, duty_we, duty_in,
    input  pwm, period_tick, busy, done, duty_act
  );

  modport slave (
    input  en, duty_we, duty_in,
    output pwm, period_tick, busy, done, duty_act
  );
endinterface

// File: rtl/pwm_cmp.sv
// Registered PWM comparator: output is high the cycle after en && cnt < duty.
module pwm_cmp
  import pwm_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o
);

  logic pwm_q;
  logic pwm_d;

  assign pwm_d = en_i && (cnt_i < duty_i);

  always_ff @(posedge clk) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_sequencer.sv
// PWM generator whose duty moves toward a written target once per period.
// Define PWM_SEQ_RAMP_EN to ramp by STEP per period; otherwise the target is applied in one jump.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERIOD = PERIOD_DEF,
  parameter int STEP   = 1
) (
  input  logic     clk,
  input  logic     reset,
  pwm_seq_if.slave bus
);

  localparam int               EXT_W    = CNT_W + 1;
  localparam logic [EXT_W-1:0] FULL_X   = EXT_W'(PERIOD + 1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

  // A full-scale duty of PERIOD+1 must be representable in CNT_W bits.
  if (STEP < 1 || PERIOD < 1 || PERIOD + 1 >= (1 << CNT_W)) begin : g_bad_cfg
    $error("pwm_sequencer: STEP must be >= 1 and PERIOD+1 must fit in CNT_W bits");
  end

  function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
    if ({1'b0, d} > FULL_X) return FULL_X[CNT_W-1:0];
    return d;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap;
  logic             wr;
  logic             pwm;

  assign wrap = bus.en && (cnt_q == PERIOD_C);
  assign wr   = bus.en && bus.duty_we;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!bus.en || wrap) cnt_d = '0;
  end

  // A write landing on the wrap cycle only reaches tgt_q afterwards, so it is used from the next wrap.
  always_comb begin
    tgt_d = tgt_q;
    if (wr) tgt_d = clamp_duty(bus.duty_in);
  end

`ifdef PWM_SEQ_RAMP_EN
  localparam logic [EXT_W-1:0] STEP_X = EXT_W'(STEP);

  function automatic logic [CNT_W-1:0] ramp_up(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] t);
    logic [EXT_W-1:0] s;
    s = {1'b0, a} + STEP_X;
    if (s > {1'b0, t}) return t;
    return s[CNT_W-1:0];
  endfunction

  // The extra top bit is the borrow; a borrow or an undershoot both settle on the target.
  function automatic logic [CNT_W-1:0] ramp_down(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] t);
    logic [EXT_W-1:0] s;
    s = {1'b0, a} - STEP_X;
    if (s[CNT_W] || (s < {1'b0, t})) return t;
    return s[CNT_W-1:0];
  endfunction

  function automatic seq_state_e dir_of(input logic [CNT_W-1:0] t,
                                        input logic [CNT_W-1:0] a);
    if (t > a) return UP;
    if (t < a) return DOWN;
    return IDLE;
  endfunction

  seq_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // State always names the direction still to travel, so IDLE coincides with act == tgt.
  always_comb begin
    state_d = state_q;
    if (wrap || wr) state_d = dir_of(tgt_d, act_d);
  end

  always_comb begin
    act_d = act_q;
    if (wrap) begin
      case (state_q)
        UP:      act_d = ramp_up(act_q, tgt_q);
        DOWN:    act_d = ramp_down(act_q, tgt_q);
        default: act_d = act_q;
      endcase
    end
  end
`else
  always_comb begin
    act_d = act_q;
    if (wrap) act_d = tgt_q;
  end
`endif

  assign busy_d = (tgt_d != act_d);
  assign done_d = busy_q && !busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tgt_q  <= '0;
      act_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tgt_q  <= tgt_d;
      act_q  <= act_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  pwm_cmp #(
    .CNT_W (CNT_W)
  ) u_pwm_cmp (
    .clk    (clk),
    .reset  (reset),
    .en_i   (bus.en),
    .cnt_i  (cnt_q),
    .duty_i (act_q),
    .pwm_o  (pwm)
  );

  assign bus.pwm         = pwm;
  assign bus.period_tick = wrap;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.duty_act    = act_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: directed scenarios plus random traffic against a period-level model.
module tb_pwm_sequencer;

  localparam int CNT_W  = 10;
  localparam int PERIOD = 9;
  localparam int STEP   = 2;
  localparam int FULL   = PERIOD + 1;
`ifdef PWM_SEQ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_seq_if #(.CNT_W(CNT_W)) bus ();

  pwm_sequencer #(
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD),
    .STEP   (STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counter position, target, applied duty and the registered outputs.
  int m_cnt = 0, m_tgt = 0, m_act = 0, m_pwm = 0, m_busy = 0, m_done = 0;
  bit m_wrap = 1'b0;

  logic r_i = 1'b1, en_i = 1'b0, we_i = 1'b0;
  int   din_i = 0;
  int   obs_hi = 0, obs_tick = 0, obs_busy = 0, obs_done = 0;

  int e34[4] = '{2, 4, 6, 7};
  int e35[4] = '{6, 4, 2, 1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit e, input bit we, input int din);
    int nt, na;
    m_wrap = 1'b0;
    if (r) begin
      m_cnt = 0; m_tgt = 0; m_act = 0; m_pwm = 0; m_busy = 0; m_done = 0;
      return;
    end
    m_pwm = (e && m_cnt < m_act) ? 1 : 0;
    nt = (e && we) ? ((din > FULL) ? FULL : din) : m_tgt;
    na = m_act;
    if (e && m_cnt == PERIOD) begin
      m_wrap = 1'b1;
`ifdef PWM_SEQ_RAMP_EN
      if (m_tgt > m_act)      na = (m_act + STEP > m_tgt) ? m_tgt : m_act + STEP;
      else if (m_tgt < m_act) na = (m_act - STEP < m_tgt) ? m_tgt : m_act - STEP;
`else
      na = m_tgt;
`endif
    end
    m_cnt  = !e ? 0 : ((m_cnt == PERIOD) ? 0 : m_cnt + 1);
    m_done = (m_busy != 0 && nt == na) ? 1 : 0;
    m_busy = (nt != na) ? 1 : 0;
    m_tgt  = nt;
    m_act  = na;
  endtask

  task automatic step();
    reset       = r_i;
    bus.en      = en_i;
    bus.duty_we = we_i;
    bus.duty_in = din_i[CNT_W-1:0];
    @(posedge clk);
    model_clock(r_i, en_i, we_i, din_i);
    #1;
    check_val("pwm",         bus.pwm,         m_pwm);
    check_val("period_tick", bus.period_tick, (en_i && m_cnt == PERIOD) ? 1 : 0);
    check_val("busy",        bus.busy,        m_busy);
    check_val("done",        bus.done,        m_done);
    check_val("duty_act",    bus.duty_act,    m_act);
    obs_hi   += int'(bus.pwm);
    obs_tick += int'(bus.period_tick);
    obs_busy += int'(bus.busy);
    obs_done += int'(bus.done);
    we_i = 1'b0;
    r_i  = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write_duty(input int d);
    we_i  = 1'b1;
    din_i = d;
    step();
  endtask

  task automatic to_wrap();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!m_wrap && k < 40);
    check_val("wrap_timeout", m_wrap, 1);
  endtask

  task automatic clear_obs();
    obs_hi = 0; obs_tick = 0; obs_busy = 0; obs_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and basic waveform with duty 4
    r_i = 1'b1; steps(1);
    r_i = 1'b1; steps(1);
    check_val("rst_act",  bus.duty_act, 0);
    check_val("rst_pwm",  bus.pwm, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    en_i = 1'b1;
    write_duty(4);
    to_wrap(); to_wrap(); to_wrap();
    clear_obs();
    steps(10);
    check_val("s33_high_cycles", obs_hi, 4);
    check_val("s33_ticks", obs_tick, 1);
    clear_obs();
    steps(30);
    check_val("s33_high_30", obs_hi, 12);
    check_val("s33_ticks_30", obs_tick, 3);

    // Ramp 0 -> 7
    r_i = 1'b1; steps(1);
    clear_obs();
    write_duty(7);
    check_val("s34_busy_rise", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      to_wrap();
      check_val("s34_act", bus.duty_act, RAMP ? e34[i] : 7);
      check_val("s34_busy", bus.busy, (RAMP && i < 3) ? 1 : 0);
      if (i == 0) check_val("s39_done_after_jump", bus.done, RAMP ? 0 : 1);
    end
    steps(2);
    check_val("s34_done_count", obs_done, 1);

    // Ramp 8 -> 1, then a redundant write
    write_duty(8);
    to_wrap();
    check_val("s35_act8", bus.duty_act, 8);
    write_duty(1);
    for (int i = 0; i < 4; i++) begin
      to_wrap();
      check_val("s35_act", bus.duty_act, RAMP ? e35[i] : 1);
    end
    steps(3);
    clear_obs();
    write_duty(1);
    steps(25);
    check_val("s35_no_busy", obs_busy, 0);
    check_val("s35_no_done", obs_done, 0);

    // Clamp to full scale, then down to zero
    write_duty(500);
    for (int i = 0; i < 6; i++) to_wrap();
    check_val("s36_clamped", bus.duty_act, FULL);
    clear_obs();
    steps(20);
    check_val("s36_const_high", obs_hi, 20);
    write_duty(0);
    for (int i = 0; i < 6; i++) to_wrap();
    check_val("s36_zero", bus.duty_act, 0);
    step();
    clear_obs();
    steps(20);
    check_val("s36_const_low", obs_hi, 0);

    // Reverse mid-ramp: at act=4 heading to 9, write 0 at cnt=5
    write_duty(9);
    to_wrap(); to_wrap();
    check_val("s37_act_mid", bus.duty_act, RAMP ? 4 : 9);
    for (int k = 0; k < 20 && m_cnt != 5; k++) step();
    check_val("s37_at_cnt5", m_cnt, 5);
    write_duty(0);
    clear_obs();
    to_wrap();
    check_val("s37_act_a", bus.duty_act, RAMP ? 2 : 0);
    to_wrap();
    check_val("s37_act_b", bus.duty_act, 0);
    steps(2);
    check_val("s37_done_once", obs_done, 1);

    // Reset mid-ramp, then hold with en low
    write_duty(10);
    to_wrap(); to_wrap(); to_wrap();
    check_val("s38_act_pre", bus.duty_act, RAMP ? 6 : 10);
    r_i = 1'b1; step();
    check_val("s38_rst_act",  bus.duty_act, 0);
    check_val("s38_rst_pwm",  bus.pwm, 0);
    check_val("s38_rst_tick", bus.period_tick, 0);
    check_val("s38_rst_busy", bus.busy, 0);
    check_val("s38_rst_done", bus.done, 0);
    clear_obs();
    steps(12);
    check_val("s38_no_done", obs_done, 0);
    check_val("s38_no_busy", obs_busy, 0);
    write_duty(5);
    to_wrap(); to_wrap(); to_wrap();
    check_val("s38_act5", bus.duty_act, 5);
    en_i = 1'b0;
    clear_obs();
    steps(30);
    check_val("s38_hold_pwm",  obs_hi, 0);
    check_val("s38_hold_tick", obs_tick, 0);
    check_val("s38_hold_act",  bus.duty_act, 5);
    check_val("s38_hold_cnt",  m_cnt, 0);
    en_i = 1'b1;

    // Random traffic against the model
    for (int k = 0; k < 2500; k++) begin
      en_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin
        we_i  = 1'b1;
        din_i = ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 1023))
                                            : int'($urandom_range(0, FULL));
      end
      if ($urandom_range(0, 399) == 0) r_i = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 10, width of counter, duty and period values.
REQ-002 SHALL have parameter PERIOD, default 999, terminal count; the PWM period is PERIOD+1 clk cycles.
REQ-003 SHALL have parameter STEP, default 1, duty increment/decrement applied per period while ramping.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1, run enable for the period counter and output.
REQ-007 SHALL have port duty_we, input, 1, one-cycle strobe loading a new duty target.
REQ-008 SHALL have port duty_in, input, CNT_W, requested duty in clk cycles high per period.
REQ-009 SHALL have port pwm, output, 1, registered PWM waveform.
REQ-010 SHALL have port period_tick, output, 1, one-cycle pulse on the cycle cnt==PERIOD while en=1.
REQ-011 SHALL have port busy, output, 1, high while the active duty differs from the target.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on the cycle after the active duty reaches the target.
REQ-013 SHALL have port duty_act, output, CNT_W, duty currently applied to the comparator.

Function
REQ-014 Counter cnt SHALL count 0..PERIOD and wrap to 0 when en=1; when en=0 it SHALL hold at 0.
REQ-015 pwm SHALL be 1 in the cycle after a cycle with en=1 and cnt < duty_act, and 0 otherwise, giving 1-cycle latency.
REQ-016 duty_in SHALL be clamped to PERIOD+1 on load; duty 0 gives constant low and PERIOD+1 gives constant high.
REQ-017 duty_we SHALL latch the clamped target in any state, and a later write SHALL override an earlier one mid-ramp.
REQ-018 duty_act SHALL change only on the cycle where cnt wraps from PERIOD to 0, so every period uses a single duty value.
REQ-019 The FSM SHALL have states IDLE, UP and DOWN, and SHALL be in IDLE when act==tgt.
REQ-020 At each wrap, the FSM SHALL enter UP if tgt>act, DOWN if tgt<act, else IDLE.
REQ-021 In UP, act SHALL become min(act+STEP, tgt) at wrap; in DOWN, act SHALL become max(act-STEP, tgt) at wrap.
REQ-022 Ramp arithmetic SHALL be computed one bit wider than CNT_W, and SHALL never overflow or underflow.
REQ-023 busy SHALL be a registered (tgt != act) and SHALL rise on the cycle after duty_we with a different value.
REQ-024 done SHALL pulse exactly once per convergence and SHALL NOT pulse for a write equal to act.
REQ-025 If a target is written on the wrap cycle itself, the write SHALL take effect from the next wrap.
REQ-026 When en=0, tgt and act SHALL be held, no ramp step SHALL occur, and pwm and period_tick SHALL be 0.

Reset
REQ-027 Reset SHALL force cnt=0, act=0, tgt=0, state=IDLE, pwm=0, period_tick=0, busy=0 and done=0 on the next clock edge.
REQ-028 Reset asserted mid-ramp SHALL discard the target, with no done pulse generated.

Configuration
REQ-029 Macro PWM_SEQ_RAMP_EN defined: ramping SHALL behave per REQ-019..REQ-021.
REQ-030 Macro PWM_SEQ_RAMP_EN undefined: act SHALL load tgt directly at the next wrap, UP and DOWN SHALL not exist, and busy/done SHALL keep their definitions.

Structure
REQ-031 Package pwm_seq_pkg SHALL hold the FSM state encoding and the default CNT_W and PERIOD constants.
REQ-032 The registered compare (cnt, duty_act, en -> pwm) SHALL be a sub-module named pwm_cmp, instantiated once.

Verification (PERIOD=9, STEP=2, CNT_W=10)
REQ-033 Reset, en=1, write 4 -> after the first wrap, pwm is high 4 cycles of every 10; period_tick is every 10th cycle.
REQ-034 Ramp build, act=0, write 7 -> act is 2,4,6,7 on successive wraps; busy high throughout; done pulses once after act=7.
REQ-035 act=8, write 1 -> act is 6,4,2,1; then write 1 again -> no busy and no done.
REQ-036 Write 500 -> clamped tgt=10, pwm constant high once reached; write 0 -> pwm constant low once reached.
REQ-037 Mid-ramp at act=4 toward 9, write 0 at cnt=5 -> next wraps give act 2,0; at most one done, after act=0.
REQ-038 Reset at act=6 during a ramp -> all outputs 0 next cycle; en=0 for 30 cycles -> cnt=0, pwm=0, act unchanged.
REQ-039 Non-ramp build, act=0, write 7 -> act=7 at the first wrap; done pulses on the following cycle.
